time_counter: RTL and testbench
===============================

# time_counter

Real-time-of-day counter for the FPGA digital clock. It divides the board clock down to a one-second tick and keeps hours, minutes and seconds in 24-hour binary format. It also lets the user set the time field by field with the pushbutton and field-select switch. Its `H_OUT`/`M_OUT`/`S_OUT` outputs are the current-time inputs consumed directly by the alarm-setting/compare stage.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per second. Must be ≥ 2. Benches use 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `SET_MODE`  in  1  level input, synchronous to `clk`.
  - 1 = time-set mode: counting halted, PB edits the time.
  - 0 = run mode.
- `PB`  in  1  raw pushbutton, asynchronous; synchronised internally.
- `SWITCH`  in  2  field select: 00 = hours, 01 = minutes, 10 = seconds, 11 = none.
- `H_OUT`  out  5  hours, 0..23.
- `M_OUT`  out  6  minutes, 0..59.
- `S_OUT`  out  6  seconds, 0..59.
- `SEC_TICK`  out  1  one-cycle pulse, high in the cycle the run-mode seconds value updates.

## Operation
- **Reset:** on any edge with `reset`=1, all of the following clear to 0, overriding everything else:
  - outputs `H_OUT`, `M_OUT`, `S_OUT`, `SEC_TICK`;
  - prescaler, PB sync flops and PB delay flop.
- **PB path:** two-flop synchroniser, then a delay flop. `pb_rise` = sync2 & ~delay. This gives one pulse per press, regardless of how long PB is held.
- **Mode selection:** two modes, chosen by the `SET_MODE` level sampled at each edge; there is no stored mode state.
- **RUN (`SET_MODE`=0):**
  - Prescaler counts 0..`TICK_DIV`−1.
  - At the edge where prescaler = `TICK_DIV`−1: prescaler returns to 0 and the time advances by one second.
  - Seconds 59 → 0 carries to minutes.
  - Minutes 59 → 0 carries to hours.
  - Hours 23 → 0, no further carry.
  - `pb_rise` is ignored.
- **SET (`SET_MODE`=1):**
  - Prescaler is held at 0; no advance and no `SEC_TICK`.
  - Each `pb_rise` increments only the field selected by `SWITCH`, with wrap: H 23 → 0, M 59 → 0, S 59 → 0.
  - No carry into other fields.
  - `SWITCH`=11: `pb_rise` has no effect.
- **Invariant:** fields never hold out-of-range values. All comparisons use exact field maxima, not bit widths.

## Timing
- After `reset` deasserts, the first seconds increment is registered on the `TICK_DIV`-th rising edge. Later increments follow every `TICK_DIV` edges.
- `SEC_TICK` is registered and is high for exactly the cycle in which the new `S_OUT` value is first visible.
- **PB latency:** the field updates on the 3rd rising edge at which PB is sampled high, counting the first.
- **PB minimum pulse:** PB must be sampled high on ≥1 edge and low on ≥1 edge between presses to be counted. A pulse that falls between two edges is lost.
- **Mode exit:** when `SET_MODE` falls, the prescaler starts from 0. The first advance comes `TICK_DIV` edges later.
- **Simultaneous events:**
  - `SET_MODE` rises on the edge a tick would occur: SET wins, no advance.
  - `reset` wins over everything.
- **`SWITCH` changes:** take effect on the next `pb_rise`. `SWITCH` is not synchronised and must be stable for ≥1 cycle around a press.
- **Outputs:** all outputs are registered, with no combinational paths from inputs.

## Structure
- **Shared package `clock_pkg`:**
  - `HOUR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59;
  - widths `HOUR_W`=5, `MINSEC_W`=6;
  - field-select encodings `SEL_HOUR`=2'b00, `SEL_MIN`=2'b01, `SEL_SEC`=2'b10.
  - The alarm stage uses the same package.
- **Sub-module `pb_edge_detect`:** synchroniser plus rising-edge pulse, with ports clk, reset, in, pulse. It is reusable by the alarm-setting stage.
- Prescaler width is derived as `$clog2(TICK_DIV)`.

## Test plan
All scenarios use `TICK_DIV`=4, a 20 ns clk, and PB presses held 2 cycles high / 2 cycles low.
1. **Run-mode counting:** reset for 5 cycles, then release with `SET_MODE`=0.
   - `S_OUT`=1 after the 4th edge and `SEC_TICK` pulses once every 4 cycles.
   - After 240 cycles the time reads 00:01:00.
2. **Set mode:**
   - `SET_MODE`=1, `SWITCH`=00, 9 presses → `H_OUT`=9.
   - `SWITCH`=01, 4 presses → `M_OUT`=4.
   - `SWITCH`=10, 6 presses → `S_OUT`=6.
   - `SEC_TICK` stays 0 throughout.
3. **Set-mode wraps and full rollover:**
   - Set 23:59:59. One extra hours press → H=0, M and S unchanged. Restore 23:59:59.
   - Drop `SET_MODE`: 4 edges later the time reads 00:00:00 with `SEC_TICK`=1.
4. **Ignored presses:**
   - PB presses in RUN → no field change.
   - `SWITCH`=11 presses in SET → no change.
   - 5 ns PB pulse between edges → no change.
5. **Reset mid-operation:** at 12:34:56 with prescaler = 2, assert `reset` for 1 cycle.
   - All outputs read 0 on the next edge.
   - The next increment comes 4 edges after release.
6. **Simultaneous tick and mode entry:** `SET_MODE` rises on the edge where prescaler = 3 → no increment and no `SEC_TICK`.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day constants and helpers for the clock datapath and the alarm stage.
package clock_pkg;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MINSEC_W = 6;

    typedef enum logic [1:0] {
        SEL_HOUR = 2'b00,
        SEL_MIN  = 2'b01,
        SEL_SEC  = 2'b10,
        SEL_NONE = 2'b11
    } field_sel_e;

    // Increment with wrap at an exact field maximum rather than the bit width.
    function automatic logic [MINSEC_W-1:0] wrap_inc(input logic [MINSEC_W-1:0] v,
                                                     input logic [MINSEC_W-1:0] maxv);
        return (v == maxv) ? '0 : v + MINSEC_W'(1);
    endfunction

endpackage

// File: rtl/pb_edge_detect.sv
// Two-flop synchroniser for a raw pushbutton followed by a one-cycle rising-edge pulse.
module pb_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~dly_q;

endmodule

// File: rtl/time_counter.sv
// 24-hour time-of-day counter: prescaled one-second advance in run mode,
// field-by-field pushbutton editing in set mode.
module time_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SET_MODE,
    input  logic                PB,
    input  logic [1:0]          SWITCH,
    output logic [HOUR_W-1:0]   H_OUT,
    output logic [MINSEC_W-1:0] M_OUT,
    output logic [MINSEC_W-1:0] S_OUT,
    output logic                SEC_TICK
);

    localparam int unsigned         PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [HOUR_W-1:0]   H_LAST   = HOUR_W'(HOUR_MAX);
    localparam logic [MINSEC_W-1:0] M_LAST   = MINSEC_W'(MIN_MAX);
    localparam logic [MINSEC_W-1:0] S_LAST   = MINSEC_W'(SEC_MAX);

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [HOUR_W-1:0]   hour_q, hour_d;
    logic [MINSEC_W-1:0] min_q, min_d;
    logic [MINSEC_W-1:0] sec_q, sec_d;
    logic                tick_q, tick_d;
    logic                pb_rise;
    logic                tick;

    pb_edge_detect u_pb (
        .clk   (clk),
        .reset (reset),
        .in    (PB),
        .pulse (pb_rise)
    );

    always_comb begin
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        // SET_MODE gates the tick so mode entry on a tick edge never advances.
        tick    = ~SET_MODE & (presc_q == PRE_LAST);
        tick_d  = tick;
        presc_d = (SET_MODE | tick) ? '0 : presc_q + PRE_W'(1);

        if (tick) begin
            sec_d = wrap_inc(sec_q, S_LAST);
            if (sec_q == S_LAST) begin
                min_d = wrap_inc(min_q, M_LAST);
                if (min_q == M_LAST) begin
                    hour_d = (hour_q == H_LAST) ? '0 : hour_q + HOUR_W'(1);
                end
            end
        end else if (SET_MODE && pb_rise) begin
            case (field_sel_e'(SWITCH))
                SEL_HOUR: hour_d = (hour_q == H_LAST) ? '0 : hour_q + HOUR_W'(1);
                SEL_MIN:  min_d  = wrap_inc(min_q, M_LAST);
                SEL_SEC:  sec_d  = wrap_inc(sec_q, S_LAST);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
        end
    end

    assign H_OUT    = hour_q;
    assign M_OUT    = min_q;
    assign S_OUT    = sec_q;
    assign SEC_TICK = tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: seconds-of-day reference model, vector table,
// directed corner sequences and a randomized run.
module tb_time_counter;

    localparam int TDIV = 4;

    logic       clk;
    logic       reset;
    logic       SET_MODE;
    logic       PB;
    logic [1:0] SWITCH;
    logic [4:0] H_OUT;
    logic [5:0] M_OUT;
    logic [5:0] S_OUT;
    logic       SEC_TICK;

    int total = 0;
    int bad   = 0;

    // Reference model: time kept as seconds since midnight.
    int m_t    = 0;
    int m_cnt  = 0;
    int m_tick = 0;
    int p1 = 0, p2 = 0, p3 = 0;   // PB as sampled 1, 2 and 3 edges ago

    time_counter #(.TICK_DIV(TDIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .SET_MODE (SET_MODE),
        .PB       (PB),
        .SWITCH   (SWITCH),
        .H_OUT    (H_OUT),
        .M_OUT    (M_OUT),
        .S_OUT    (S_OUT),
        .SEC_TICK (SEC_TICK)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int h, mi, s, rise;
        if (reset) begin
            m_t = 0; m_cnt = 0; m_tick = 0; p1 = 0; p2 = 0; p3 = 0;
        end else begin
            rise = (p2 != 0 && p3 == 0) ? 1 : 0;
            p3 = p2; p2 = p1; p1 = PB ? 1 : 0;
            m_tick = 0;
            if (SET_MODE) begin
                m_cnt = 0;
                if (rise != 0) begin
                    h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
                    case (SWITCH)
                        2'b00: h  = (h + 1) % 24;
                        2'b01: mi = (mi + 1) % 60;
                        2'b10: s  = (s + 1) % 60;
                        default: ;
                    endcase
                    m_t = h * 3600 + mi * 60 + s;
                end
            end else begin
                m_cnt++;
                if (m_cnt == TDIV) begin
                    m_cnt = 0;
                    m_t = (m_t + 1) % 86400;
                    m_tick = 1;
                end
            end
        end
    endtask

    // One clock: advance model with current inputs, then compare just after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_H", int'(H_OUT), m_t / 3600);
        chk("model_M", int'(M_OUT), (m_t / 60) % 60);
        chk("model_S", int'(S_OUT), m_t % 60);
        chk("model_TICK", int'(SEC_TICK), m_tick);
    endtask

    task automatic press();
        PB = 1'b1; step(); step();
        PB = 1'b0; step(); step();
    endtask

    task automatic presses(input logic [1:0] sw, input int n);
        SWITCH = sw;
        for (int i = 0; i < n; i++) press();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic chk_time(input string nm, input int h, input int m, input int s);
        chk({nm, "_H"}, int'(H_OUT), h);
        chk({nm, "_M"}, int'(M_OUT), m);
        chk({nm, "_S"}, int'(S_OUT), s);
    endtask

    typedef struct {
        bit       set_mode;
        bit [1:0] sw;
        int       npress;
        int       eh;
        int       em;
        int       es;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int tick_cnt;
        tbl[0] = '{1'b1, 2'b00, 9, 9, 0, 0};
        tbl[1] = '{1'b1, 2'b01, 4, 9, 4, 0};
        tbl[2] = '{1'b1, 2'b10, 6, 9, 4, 6};
        tbl[3] = '{1'b1, 2'b11, 3, 9, 4, 6};
        tbl[4] = '{1'b0, 2'b00, 2, 9, 4, 8};   // run mode: presses ignored, 8 cycles = 2 s

        reset = 1'b1; SET_MODE = 1'b0; PB = 1'b0; SWITCH = 2'b00;

        // Run-mode counting after a 5-cycle reset.
        do_reset(5);
        chk_time("reset", 0, 0, 0);
        chk("reset_TICK", int'(SEC_TICK), 0);
        step(); step(); step();
        chk("pre_first_S", int'(S_OUT), 0);
        step();
        chk("first_S", int'(S_OUT), 1);
        chk("first_TICK", int'(SEC_TICK), 1);
        tick_cnt = 1;
        for (int i = 4; i < 240; i++) begin
            step();
            if (SEC_TICK) tick_cnt++;
        end
        chk_time("one_min", 0, 1, 0);
        chk("tick_count", tick_cnt, 60);

        // Vector table: set-mode edits, ignored SWITCH=11 and run-mode presses.
        SET_MODE = 1'b1;
        do_reset(1);
        foreach (tbl[i]) begin
            SET_MODE = tbl[i].set_mode;
            presses(tbl[i].sw, tbl[i].npress);
            chk_time($sformatf("tbl%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es);
        end

        // 5 ns PB glitch between edges is not seen.
        SET_MODE = 1'b1; SWITCH = 2'b10;
        step();
        #2 PB = 1'b1;
        #5 PB = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk_time("glitch", 9, 4, 8);

        // Set-mode wraps and full-day rollover.
        do_reset(1);
        presses(2'b00, 23);
        presses(2'b01, 59);
        presses(2'b10, 59);
        chk_time("set_max", 23, 59, 59);
        presses(2'b00, 1);
        chk_time("hour_wrap", 0, 59, 59);
        presses(2'b00, 23);
        presses(2'b01, 1);
        chk_time("min_wrap", 23, 0, 59);
        presses(2'b01, 59);
        presses(2'b10, 1);
        chk_time("sec_wrap", 23, 59, 0);
        presses(2'b10, 59);
        chk_time("restore", 23, 59, 59);
        SET_MODE = 1'b0;
        step(); step(); step();
        chk_time("pre_roll", 23, 59, 59);
        step();
        chk_time("rollover", 0, 0, 0);
        chk("roll_TICK", int'(SEC_TICK), 1);

        // Reset mid-operation at 12:34:56 with prescaler at 2.
        SET_MODE = 1'b1;
        do_reset(1);
        presses(2'b00, 12);
        presses(2'b01, 34);
        presses(2'b10, 56);
        SET_MODE = 1'b0;
        step(); step();
        chk_time("pre_rst", 12, 34, 56);
        do_reset(1);
        chk_time("mid_rst", 0, 0, 0);
        chk("mid_rst_TICK", int'(SEC_TICK), 0);
        step(); step(); step();
        chk("post_rst_S3", int'(S_OUT), 0);
        step();
        chk("post_rst_S4", int'(S_OUT), 1);

        // SET_MODE rising on the tick edge suppresses the advance.
        do_reset(1);
        step(); step(); step();
        SET_MODE = 1'b1;
        step();
        chk("sim_S", int'(S_OUT), 0);
        chk("sim_TICK", int'(SEC_TICK), 0);
        SET_MODE = 1'b0;
        step(); step(); step();
        chk("exit_S3", int'(S_OUT), 0);
        step();
        chk("exit_S4", int'(S_OUT), 1);

        // Randomized mix of modes, presses, field selects and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 47) == 0) SET_MODE = ~SET_MODE;
            if ($urandom_range(0, 7) == 0) SWITCH = 2'($urandom_range(0, 3));
            PB    = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
